// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bus bridge.
package dmem_bridge_pkg;

  // Bridge sequencing: wait for an access, run the bus cycle, hand the result back.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Value returned to the datapath when an access is aborted or misaligned.
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Latched copy of one bus request, held stable for the whole bus cycle.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  // Word accesses only: the two low address bits must be zero.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Valid/ack data-memory bus between the bridge (master) and the memory (slave).
interface dmem_bridge_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );

endinterface

// File: rtl/dmem_timeout_ctr.sv
// Clearable up-counter that flags when an outstanding bus request has
// waited its full allowance of cycles.
module dmem_timeout_ctr #(
  parameter int TIMEOUT = 16,
  parameter int CW      = $clog2(TIMEOUT) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  logic [CW-1:0] r_count;

  // Count request cycles; restart from zero when a new request is launched.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, regardless of statement order between blocks.
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Terminal count is the last cycle the request may wait for an ack.
  assign o_tc = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the single-cycle datapath's load/store request onto a slow
// valid/ack memory bus, stalling the datapath until the access completes.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        BusErr,
  input  logic        ErrClr,
  dmem_bridge_if.master bus
);

  state_e      r_state;
  bus_req_t    r_req;
  logic [31:0] r_rdata;
  logic        r_bus_err;

  logic w_acc;
  logic w_aligned;
  logic w_start;
  logic w_in_req;
  logic w_tc;
  logic w_err_set;

  // A store wins when both strobes are set.
  assign w_acc     = MemRead | MemWrite;
  assign w_aligned = is_word_aligned(Addr);
  assign w_start   = (r_state == ST_IDLE) && w_acc && w_aligned;
  assign w_in_req  = (r_state == ST_REQ);

  // Errors come from a misaligned address or a request that never saw an ack.
  assign w_err_set = ((r_state == ST_IDLE) && w_acc && !w_aligned) ||
                     (w_in_req && !bus.bus_ack && w_tc);

  dmem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_start),
    .i_en    (w_in_req),
    .o_tc    (w_tc)
  );

  // Access sequencer: latch the request, wait for ack or timeout, capture result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_req     <= '0;
      r_rdata   <= '0;
      r_bus_err <= 1'b0;
    end else begin
      // A new error outranks a simultaneous clear.
      r_bus_err <= w_err_set | (r_bus_err & ~ErrClr);

      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            if (w_aligned) begin
              r_req   <= '{we: MemWrite, addr: {Addr[31:2], 2'b00}, wdata: WriteData};
              r_state <= ST_REQ;
            end else begin
              r_rdata <= ERR_DATA;
              r_state <= ST_DONE;
            end
          end
        end
        ST_REQ: begin
          // An ack on the terminal-count cycle still completes normally.
          if (bus.bus_ack) begin
            if (!r_req.we) begin
              r_rdata <= bus.bus_rdata;
            end
            r_state <= ST_DONE;
          end else if (w_tc) begin
            r_rdata <= ERR_DATA;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Datapath commits this cycle; never re-issue the same access.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall covers the decode cycle combinationally and every bus-wait cycle.
  assign Stall = ((r_state == ST_IDLE) && w_acc) || w_in_req;

  assign ReadData      = r_rdata;
  assign BusErr        = r_bus_err;
  assign bus.bus_req   = w_in_req;
  assign bus.bus_we    = r_req.we;
  assign bus.bus_addr  = r_req.addr;
  assign bus.bus_wdata = r_req.wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: an instruction-level model predicts
// the per-cycle Stall/bus/ReadData/BusErr trace; a negedge process compares.
module tb_dmem_bridge;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, ErrClr;
  logic [31:0] Addr, WriteData;
  logic [31:0] ReadData;
  logic        Stall, BusErr;

  dmem_bridge_if bus_if ();

  dmem_bridge #(
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .BusErr    (BusErr),
    .ErrClr    (ErrClr),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt = 0;
  int req_cnt   = 0;

  // Expected outputs for the current cycle
  logic        exp_valid = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;

  // Model state: captured read value and sticky error
  logic [31:0] m_rdata = '0;
  logic        m_err   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model's expectation
  always @(negedge clk) begin
    if (exp_valid) begin
      if (Stall) stall_cnt <= stall_cnt + 1;
      if (bus_if.bus_req) req_cnt <= req_cnt + 1;
      check("stall",   32'(Stall),          32'(exp_stall));
      check("bus_req", 32'(bus_if.bus_req), 32'(exp_req));
      if (exp_req) begin
        check("bus_we",    32'(bus_if.bus_we), 32'(exp_we));
        check("bus_addr",  bus_if.bus_addr,    exp_addr);
        check("bus_wdata", bus_if.bus_wdata,   exp_wdata);
      end
      check("read_data", ReadData,    exp_rdata);
      check("bus_err",   32'(BusErr), 32'(exp_err));
    end
  end

  // One datapath instruction. ack_at is the REQ cycle index (0-based) of the
  // ack; ack_at >= TO means no ack in time (timeout), with a late ack in DONE
  // when ack_at == TO. clr_mode: 0 none, 1 random, 2 held high.
  task automatic do_instr(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int ack_at,
                          input logic [31:0] ack_data, input int clr_mode);
    logic acc, aligned, err_set;
    bit   in_req, acked;
    int   n_req, total;
    acc     = rd | wr;
    aligned = (addr[1:0] == 2'b00);
    n_req   = 0;
    if (!acc)          total = 1;
    else if (!aligned) total = 2;
    else begin
      n_req = (ack_at < TO) ? ack_at + 1 : TO;
      total = n_req + 2;
    end
    for (int c = 0; c < total; c++) begin
      in_req    = acc && aligned && (c >= 1) && (c <= n_req);
      acked     = in_req && (c - 1 == ack_at);
      MemRead   = rd;
      MemWrite  = wr;
      Addr      = addr;
      WriteData = wd;
      ErrClr    = (clr_mode == 2) ? 1'b1 :
                  (clr_mode == 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (in_req) bus_if.bus_ack = acked;
      else        bus_if.bus_ack = (c - 1 == ack_at) || ($urandom_range(0, 3) == 0);
      bus_if.bus_rdata = acked ? ack_data : $urandom;
      exp_stall = (c != total - 1);
      exp_req   = in_req;
      exp_we    = wr;
      exp_addr  = {addr[31:2], 2'b00};
      exp_wdata = wd;
      exp_rdata = m_rdata;
      exp_err   = m_err;
      exp_valid = 1'b1;
      @(posedge clk); #1;
      err_set = 1'b0;
      if (acc && !aligned && c == 0) begin
        m_rdata = ERR;
        err_set = 1'b1;
      end
      if (in_req && c == n_req) begin
        if (acked) begin
          if (!wr) m_rdata = ack_data;
        end else begin
          m_rdata = ERR;
          err_set = 1'b1;
        end
      end
      m_err = err_set | (m_err & ~ErrClr);
    end
    bus_if.bus_ack = 1'b0;
  endtask

  // Assert reset in the middle of a bus request
  task automatic reset_mid();
    exp_valid = 1'b0;
    MemRead = 1'b1; MemWrite = 1'b0; Addr = 32'h40; WriteData = 32'h0;
    ErrClr = 1'b0; bus_if.bus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_pre_req", 32'(bus_if.bus_req), 32'd1);
    #2;
    reset   = 1'b0;
    MemRead = 1'b0;
    #1;
    check("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
    check("rst_stall",   32'(Stall),          32'd0);
    check("rst_rdata",   ReadData,            32'd0);
    check("rst_bus_err", 32'(BusErr),         32'd0);
    m_rdata = '0;
    m_err   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  int          s0, r0;
  logic [31:0] a;

  initial begin
    reset = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; ErrClr = 1'b0;
    Addr = '0; WriteData = '0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    #3;
    check("reset_stall",   32'(Stall),           32'd0);
    check("reset_bus_req", 32'(bus_if.bus_req),  32'd0);
    check("reset_bus_we",  32'(bus_if.bus_we),   32'd0);
    check("reset_addr",    bus_if.bus_addr,      32'd0);
    check("reset_wdata",   bus_if.bus_wdata,     32'd0);
    check("reset_rdata",   ReadData,             32'd0);
    check("reset_bus_err", 32'(BusErr),          32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Read, ack on the third REQ cycle
    s0 = stall_cnt; r0 = req_cnt;
    do_instr(1'b1, 1'b0, 32'h100, 32'h0, 2, 32'h12345678, 0);
    check("rd_stall_cycles", 32'(stall_cnt - s0), 32'd4);
    check("rd_req_cycles",   32'(req_cnt - r0),   32'd3);
    check("rd_data",         ReadData,            32'h12345678);

    // Write, immediate ack; ReadData untouched
    s0 = stall_cnt; r0 = req_cnt;
    do_instr(1'b0, 1'b1, 32'h204, 32'hCAFEF00D, 0, 32'h0, 0);
    check("wr_stall_cycles", 32'(stall_cnt - s0), 32'd2);
    check("wr_req_cycles",   32'(req_cnt - r0),   32'd1);
    check("wr_rdata_kept",   ReadData,            32'h12345678);

    // Misaligned read: no bus cycle, error data, sticky error until cleared
    s0 = stall_cnt; r0 = req_cnt;
    do_instr(1'b1, 1'b0, 32'h103, 32'h0, 0, 32'h0, 0);
    check("mis_stall_cycles", 32'(stall_cnt - s0), 32'd1);
    check("mis_req_cycles",   32'(req_cnt - r0),   32'd0);
    check("mis_rdata",        ReadData,            32'hDEADBEEF);
    check("mis_bus_err",      32'(BusErr),         32'd1);
    do_instr(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0, 2);
    check("mis_err_cleared",  32'(BusErr),         32'd0);

    // Timeout with a late ack in DONE
    s0 = stall_cnt; r0 = req_cnt;
    do_instr(1'b1, 1'b0, 32'h300, 32'h0, TO, 32'h55555555, 0);
    check("to_req_cycles",  32'(req_cnt - r0),   32'd4);
    check("to_stall_cycles", 32'(stall_cnt - s0), 32'd5);
    check("to_rdata",       ReadData,            32'hDEADBEEF);
    check("to_bus_err",     32'(BusErr),         32'd1);
    do_instr(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0, 2);

    // Ack on the terminal-count cycle completes normally
    do_instr(1'b1, 1'b0, 32'h380, 32'h0, TO - 1, 32'h0F0F0F0F, 0);
    check("tc_ack_rdata",   ReadData,    32'h0F0F0F0F);
    check("tc_ack_bus_err", 32'(BusErr), 32'd0);

    // Back-to-back loads
    do_instr(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'hA5A50001, 0);
    check("b2b_first",  ReadData, 32'hA5A50001);
    do_instr(1'b1, 1'b0, 32'h14, 32'h0, 0, 32'h5A5A0002, 0);
    check("b2b_second", ReadData, 32'h5A5A0002);

    // Both strobes: treated as a store
    do_instr(1'b1, 1'b1, 32'h48, 32'h13572468, 1, 32'h99999999, 0);
    check("both_is_write", ReadData, 32'h5A5A0002);

    // Reset mid-transaction, then a normal access
    reset_mid();
    do_instr(1'b1, 1'b0, 32'h44, 32'h0, 1, 32'h0BADF00D, 0);
    check("post_rst_rdata", ReadData, 32'h0BADF00D);

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      int kind;
      kind = $urandom_range(0, 4);
      a = $urandom;
      a[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_instr((kind == 1) || (kind == 2) || (kind == 4), (kind >= 3), a, $urandom,
               $urandom_range(0, TO), $urandom, 1);
    end

    exp_valid = 1'b0;
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
